// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences a processor through reset, a bounded run window
// and a register-file dump over a valid/ready stream.
// Optional feature: define CORE_RUN_CTRL_CYCLE_COUNT_EN to count executed
// core cycles on cycle_count; otherwise cycle_count is tied to zero.
module core_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int RUN_CYCLES   = 20,
  parameter int NUM_REGS     = 32,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  output logic            core_rst,
  output logic            core_en,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            busy,
  output logic            done,
  output logic [31:0]     cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Last phase-counter value of each timed phase; a zero-length phase
  // degenerates to a single cycle.
  localparam logic [15:0] RESET_LAST = 16'((RESET_CYCLES > 1) ? (RESET_CYCLES - 1) : 0);
  localparam logic [15:0] RUN_LAST   = 16'((RUN_CYCLES > 1) ? (RUN_CYCLES - 1) : 0);
  localparam logic [4:0]  LAST_IDX   = 5'((NUM_REGS > 1) ? (NUM_REGS - 1) : 0);

  state_t      state;
  logic [15:0] phase;

  // Phase counter saturates so a long-lived phase never wraps.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // The debug read port follows the dump index; data is only exposed
  // while a beat is being offered.
  assign rf_raddr  = dump_idx;
  assign dump_data = dump_valid ? rf_rdata : '0;

  // Sequencer: state, phase counter and all registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      core_rst   <= 1'b1;
      core_en    <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_RESET;
            phase    <= '0;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end else begin
            phase <= sat_inc(phase);
          end
        end

        ST_RESET: begin
          if (phase == RESET_LAST) begin
            state    <= ST_RUN;
            phase    <= '0;
            core_rst <= 1'b0;
            core_en  <= 1'b1;
          end else begin
            phase <= sat_inc(phase);
          end
        end

        ST_RUN: begin
          // A halted cycle still executed; the core freezes from the next one.
          if (halt_req || (phase == RUN_LAST)) begin
            state      <= ST_DUMP;
            phase      <= '0;
            core_en    <= 1'b0;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
          end else begin
            phase <= sat_inc(phase);
          end
        end

        ST_DUMP: begin
          if (dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state      <= ST_DONE;
              phase      <= '0;
              dump_valid <= 1'b0;
              dump_idx   <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 5'd1;
              phase    <= sat_inc(phase);
            end
          end else begin
            phase <= sat_inc(phase);
          end
        end

        default: begin
          state      <= ST_IDLE;
          phase      <= '0;
          core_rst   <= 1'b1;
          core_en    <= 1'b0;
          dump_valid <= 1'b0;
          dump_idx   <= '0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORE_RUN_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;

  // Executed-cycle counter: cleared when a new sequence starts, counts
  // every RUN cycle and holds through DUMP and DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
    end else if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
      cyc_cnt <= '0;
    end else if (state == ST_RUN) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign cycle_count = cyc_cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed sequences with a dump-stream scoreboard.
module tb_core_run_ctrl;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;

`ifdef CORE_RUN_CTRL_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            halt_req = 1'b0;
  logic            core_rst;
  logic            core_en;
  logic [4:0]      rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            dump_valid;
  logic            dump_ready = 1'b1;
  logic [4:0]      dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            busy;
  logic            done;
  logic [31:0]     cycle_count;

  int tests = 0;
  int fails = 0;

  logic [4:0]  exp_idx_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  core_run_ctrl #(
    .RESET_CYCLES(2), .RUN_CYCLES(20), .NUM_REGS(NUM_REGS), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .core_rst(core_rst), .core_en(core_en),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  // Register-file model: distinct content per address.
  function automatic logic [31:0] regval(input logic [4:0] a);
    return {a, 3'b101, ~a, 3'b010, a ^ 5'h15, 3'b110, 8'h3C};
  endfunction

  assign rf_rdata = regval(rf_raddr);

  function automatic logic [31:0] exp_cc(input int n);
    return CC_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_dump();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_idx_q.push_back(5'(i));
      exp_data_q.push_back(regval(5'(i)));
    end
  endtask

  // Called at posedge+1; start is seen by exactly one edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: every accepted dump beat is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst && dump_valid && dump_ready) begin
      if (exp_idx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got idx %0d with nothing expected", dump_idx);
      end else begin
        check("beat_idx", 32'(dump_idx), 32'(exp_idx_q.pop_front()));
        check("beat_data", dump_data, exp_data_q.pop_front());
      end
    end
  end

  // Drives one sequence from its first RESET cycle until done.
  task automatic run_seq(input int halt_at, input int stall_idx, input int start_at,
                         output int en_cycles, output int rst_cycles);
    int          stall_left;
    logic [31:0] held;
    bit          finished;
    stall_left = -1;
    held       = '0;
    finished   = 1'b0;
    en_cycles  = 0;
    rst_cycles = 0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (busy && core_rst) rst_cycles++;
      halt_req = 1'b0;
      start    = 1'b0;
      if (core_en) begin
        en_cycles++;
        if (en_cycles == halt_at)  halt_req = 1'b1;
        if (en_cycles == start_at) start    = 1'b1;
      end
      if (!dump_valid) check("idle_dump_data", dump_data, 32'd0);
      if (stall_left < 0 && dump_valid && (32'(dump_idx) == stall_idx)) begin
        held = dump_data;
        check("stall_first_data", dump_data, regval(5'(stall_idx)));
        stall_left = 3;
      end else if (stall_left > 0) begin
        check("stall_idx", 32'(dump_idx), 32'(stall_idx));
        check("stall_data", dump_data, held);
        check("stall_valid", 32'(dump_valid), 32'd1);
      end
      if (stall_left > 0) begin
        dump_ready = 1'b0;
        stall_left--;
      end else begin
        dump_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    halt_req   = 1'b0;
    start      = 1'b0;
    dump_ready = 1'b1;
    if (!finished) begin
      tests++;
      fails++;
      $display("FAIL seq_timeout: done not reached within 400 cycles");
    end
  endtask

  task automatic check_done(input string tag, input int en, input int rc,
                            input int exp_en, input int exp_cyc);
    check({tag, "_en_cycles"}, 32'(en), 32'(exp_en));
    check({tag, "_rst_cycles"}, 32'(rc), 32'd2);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check({tag, "_core_en"}, 32'(core_en), 32'd0);
    check({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_dump_idx"}, 32'(dump_idx), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, exp_cc(exp_cyc));
    check({tag, "_beats_left"}, 32'(exp_idx_q.size()), 32'd0);
  endtask

  initial begin
    int en;
    int rc;
    int cnt;
    bit resumed;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_idx", 32'(dump_idx), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full default sequence
    push_dump();
    pulse_start();
    run_seq(0, -1, 0, en, rc);
    check_done("full", en, rc, 20, 20);

    // Early halt on the 5th RUN cycle
    push_dump();
    pulse_start();
    run_seq(5, -1, 0, en, rc);
    check_done("halt", en, rc, 5, 5);

    // Back-pressure at idx 7
    push_dump();
    pulse_start();
    run_seq(0, 7, 0, en, rc);
    check_done("stall", en, rc, 20, 20);

    // start during RUN is ignored
    push_dump();
    pulse_start();
    run_seq(0, -1, 3, en, rc);
    check_done("start_in_run", en, rc, 20, 20);

    // start in DONE begins a new sequence with cycle_count cleared
    pulse_start();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_core_rst", 32'(core_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_cycle_count", cycle_count, 32'd0);
    push_dump();
    run_seq(0, -1, 0, en, rc);
    check_done("restart", en, rc, 20, 20);

    // Asynchronous reset in the middle of RUN
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (core_en) cnt++;
      if (cnt == 4) break;
      @(posedge clk); #1;
    end
    check("midrun_reached_run", 32'(cnt), 32'd4);
    rst = 1'b0;
    #1;
    check("midrun_core_rst", 32'(core_rst), 32'd1);
    check("midrun_core_en", 32'(core_en), 32'd0);
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_done", 32'(done), 32'd0);
    check("midrun_dump_valid", 32'(dump_valid), 32'd0);
    check("midrun_cycle_count", cycle_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    resumed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy || core_en || !core_rst || dump_valid || done) resumed = 1'b1;
      @(posedge clk); #1;
    end
    check("midrun_no_resume", 32'(resumed), 32'd0);
    check("midrun_beats_left", 32'(exp_idx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: number of cycles the core is held in reset after start.
REQ-002 SHALL have parameter RUN_CYCLES, default 20: maximum number of cycles the core runs (1..2^16-1).
REQ-003 SHALL have parameter NUM_REGS, default 32: number of architectural registers dumped.
REQ-004 SHALL have parameter XLEN, default 32: register data width.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  one-cycle request to begin a reset/run/dump sequence.
REQ-008 SHALL have port halt_req  in  1  early stop of the run phase.
REQ-009 SHALL have port core_rst  out  1  active-high reset to the processor.
REQ-010 SHALL have port core_en  out  1  clock enable to the processor; the core advances only when high.
REQ-011 SHALL have port rf_raddr  out  5  register-file debug read address.
REQ-012 SHALL have port rf_rdata  in  XLEN  register-file debug read data, combinational from rf_raddr.
REQ-013 SHALL have port dump_valid  out  1, dump_ready  in  1, dump_idx  out  5, dump_data  out  XLEN: register dump stream.
REQ-014 SHALL have port busy  out  1 and done  out  1: sequence status.
REQ-015 SHALL have port cycle_count  out  32: core cycles executed in the last run.

Function
REQ-016 SHALL implement states IDLE, RESET, RUN, DUMP, DONE.
REQ-017 SHALL, in IDLE or DONE, move to RESET on the edge where start=1; start SHALL be ignored in RESET, RUN and DUMP.
REQ-018 SHALL assert core_rst=1, core_en=0 in IDLE and RESET; core_rst=0 in RUN, DUMP and DONE.
REQ-019 SHALL stay in RESET for exactly RESET_CYCLES cycles, then enter RUN.
REQ-020 SHALL assert core_en=1 only in RUN, for exactly RUN_CYCLES cycles, then enter DUMP.
REQ-021 SHALL, when halt_req=1 during a RUN cycle, count that cycle as executed, deassert core_en from the next cycle and enter DUMP.
REQ-022 SHALL, in DUMP, drive rf_raddr=dump_idx, dump_data=rf_rdata and dump_valid=1, starting with dump_idx=0.
REQ-023 SHALL hold dump_idx and dump_valid stable until dump_valid and dump_ready are both high on a clock edge; dump_idx then increments by 1.
REQ-024 SHALL, on acceptance of dump_idx=NUM_REGS-1, enter DONE with dump_valid=0 and dump_idx=0.
REQ-025 SHALL keep dump_valid=0 and dump_data=0 outside DUMP.
REQ-026 SHALL assert busy=1 in RESET, RUN and DUMP; done=1 only in DONE.
REQ-027 SHALL keep the core frozen (core_en=0, core_rst=0) in DUMP and DONE so register contents stay stable.
REQ-028 SHALL use a 16-bit phase counter that clears on every state change and never wraps within a phase.

Reset
REQ-029 SHALL, on rst=0, immediately force state IDLE, core_rst=1, core_en=0, dump_valid=0, dump_idx=0, busy=0, done=0, cycle_count=0, regardless of current phase.
REQ-030 SHALL ignore start on the first edge after rst deasserts only if rst is still low at that edge.

Configuration
REQ-031 SHALL, with macro CORE_RUN_CTRL_CYCLE_COUNT_EN defined, clear cycle_count on entry to RESET and increment it on every RUN cycle, holding it through DUMP and DONE.
REQ-032 SHALL, without CORE_RUN_CTRL_CYCLE_COUNT_EN, tie cycle_count to 0 and contain no counter logic for it.

Verification
REQ-033 SHALL verify: rst low mid-RUN -> core_rst=1, core_en=0, busy=0 in the same cycle; the sequence does not resume.
REQ-034 SHALL verify: start pulse, defaults, dump_ready=1 -> core_rst high 2 cycles, core_en high 20 cycles, 32 beats idx 0..31, done=1.
REQ-035 SHALL verify: halt_req=1 on 5th RUN cycle -> core_en high exactly 5 cycles; cycle_count=5 with macro, 0 without.
REQ-036 SHALL verify: dump_ready low 3 cycles at idx 7 -> dump_idx=7, dump_data stable, dump_valid=1 for all 3 cycles.
REQ-037 SHALL verify: start during RUN -> no effect; start in DONE -> new RESET phase, cycle_count cleared to 0.
